// File: rtl/param_bram_arbiter.sv
// Round-robin arbiter sharing the parameter BRAM read port between the bias
// fetch path (requester 0) and the weight fetch path (requester 1). Each
// granted burst issues sequential reads. The read data comes back tagged with
// its owner, and a done pulse marks the last word of the burst.
module param_bram_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 5,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ap_done,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [LEN_W-1:0]  req0_len,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [LEN_W-1:0]  req1_len,
    output logic              req1_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd0_valid,
    output logic              rd1_valid,
    output logic              done0,
    output logic              done1,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout
);

    // S_ZERO holds off the next grant for one cycle after a zero-length burst
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2,
        S_ZERO  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              bram_en_d;
    logic [ADDR_W-1:0] bram_addr_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_own_q, tag_own_d;
    logic [RD_LAT-1:0] tag_last_q, tag_last_d;
    logic              rd0_valid_d, rd1_valid_d, done0_d, done1_d;

    logic              grant0, grant1, hs, hs_owner;
    logic [ADDR_W-1:0] hs_addr;
    logic [LEN_W-1:0]  hs_len;
    logic              issue, issue_own, issue_last, zero_done;
    logic [ADDR_W-1:0] issue_addr;

    // Round-robin grant: only in IDLE, and never during reset or a layer-end clear
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && !ap_done && state_q == S_IDLE) begin
            if (req0_valid && (!req1_valid || last_grant_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign hs         = grant0 | grant1;
    assign hs_owner   = grant1;
    assign hs_addr    = grant1 ? req1_addr : req0_addr;
    assign hs_len     = grant1 ? req1_len  : req0_len;
    assign rd_data    = bram_dout;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            base_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            bram_en      <= 1'b0;
            bram_addr    <= '0;
            tag_vld_q    <= '0;
            tag_own_q    <= '0;
            tag_last_q   <= '0;
            rd0_valid    <= 1'b0;
            rd1_valid    <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            base_q       <= base_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            bram_en      <= bram_en_d;
            bram_addr    <= bram_addr_d;
            tag_vld_q    <= tag_vld_d;
            tag_own_q    <= tag_own_d;
            tag_last_q   <= tag_last_d;
            rd0_valid    <= rd0_valid_d;
            rd1_valid    <= rd1_valid_d;
            done0        <= done0_d;
            done1        <= done1_d;
        end
    end

    // Next-state: DRAIN leaves the cycle after the last word's done pulse
    always_comb begin
        state_d = state_q;
        if (ap_done) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (hs) state_d = (hs_len == '0) ? S_ZERO : S_BURST;
                S_BURST: if (cnt_q == len_q) state_d = S_DRAIN;
                S_DRAIN: if (done0 || done1) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs: issue reads, shift owner tags alongside BRAM latency, flag completion
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        base_d       = base_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        issue        = 1'b0;
        issue_own    = owner_q;
        issue_last   = 1'b0;
        issue_addr   = bram_addr;
        zero_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    last_grant_d = hs_owner;
                    owner_d      = hs_owner;
                    base_d       = hs_addr;
                    len_d        = hs_len;
                    cnt_d        = '0;
                    issue_own    = hs_owner;
                    if (hs_len != '0) begin
                        issue      = 1'b1;
                        issue_addr = hs_addr;
                        issue_last = (hs_len == LEN_W'(1));
                        cnt_d      = LEN_W'(1);
                    end else begin
                        zero_done  = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (cnt_q != len_q) begin
                    issue      = 1'b1;
                    issue_addr = base_q + ADDR_W'(cnt_q);
                    issue_last = (cnt_q == len_q - LEN_W'(1));
                    cnt_d      = cnt_q + LEN_W'(1);
                end
            end
            default: ;
        endcase

        bram_en_d   = issue;
        bram_addr_d = issue_addr;
        tag_vld_d   = RD_LAT'({tag_vld_q, issue});
        tag_own_d   = RD_LAT'({tag_own_q, issue_own});
        tag_last_d  = RD_LAT'({tag_last_q, issue_last});
        rd0_valid_d = tag_vld_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
        rd1_valid_d = tag_vld_q[RD_LAT-1] &  tag_own_q[RD_LAT-1];
        done0_d     = (rd0_valid_d & tag_last_q[RD_LAT-1]) | (zero_done & ~issue_own);
        done1_d     = (rd1_valid_d & tag_last_q[RD_LAT-1]) | (zero_done &  issue_own);

        // Layer-end clear discards the burst and everything in flight
        if (ap_done) begin
            last_grant_d = 1'b1;
            owner_d      = 1'b0;
            base_d       = '0;
            len_d        = '0;
            cnt_d        = '0;
            bram_en_d    = 1'b0;
            bram_addr_d  = '0;
            tag_vld_d    = '0;
            tag_own_d    = '0;
            tag_last_d   = '0;
            rd0_valid_d  = 1'b0;
            rd1_valid_d  = 1'b0;
            done0_d      = 1'b0;
            done1_d      = 1'b0;
        end
    end

endmodule

// File: tb/tb_param_bram_arbiter.sv
// Bench for param_bram_arbiter: a cycle-indexed timeline model built from
// handshake times and burst lengths, plus a latency-accurate BRAM model.
module tb_param_bram_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned RD_LAT = 2;
    localparam int          MAXC   = 2048;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ap_done = 1'b0;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
    logic [LEN_W-1:0]  req0_len = '0, req1_len = '0;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd0_valid, rd1_valid, done0, done1, bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;

    param_bram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ap_done(ap_done),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
        .rd_data(rd_data), .rd0_valid(rd0_valid), .rd1_valid(rd1_valid),
        .done0(done0), .done1(done1),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    // BRAM contents are a fixed function of the address
    function automatic logic [63:0] mem(input logic [ADDR_W-1:0] a);
        return {20'hC0FFE, a, 32'(a) * 32'h9E3779B1};
    endfunction

    // BRAM read pipeline: data for an enable in cycle t is presented in cycle t+RD_LAT
    logic [ADDR_W-1:0] bp_addr [RD_LAT];
    logic [RD_LAT-1:0] bp_vld = '0;
    always @(posedge clk) begin
        bp_vld     <= RD_LAT'({bp_vld, bram_en});
        bp_addr[0] <= bram_addr;
        for (int i = 1; i < RD_LAT; i++) bp_addr[i] <= bp_addr[i-1];
    end
    assign bram_dout = bp_vld[RD_LAT-1] ? mem(bp_addr[RD_LAT-1]) : 64'h0BAD_0BAD_0BAD_0BAD;

    // Expected timeline, indexed by cycle number
    bit                e_en    [MAXC];
    logic [ADDR_W-1:0] e_addr  [MAXC];
    bit                e_rd0   [MAXC];
    bit                e_rd1   [MAXC];
    logic [ADDR_W-1:0] e_daddr [MAXC];
    bit                e_dn0   [MAXC];
    bit                e_dn1   [MAXC];
    int                cyc = 0;
    int                free_at = 0;
    bit                lg = 1'b1;
    int                vectors = 0;
    int                errors = 0;
    int                obs_grants [$];
    int                exp_g [4] = '{0, 1, 0, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            e_en[i] = 0; e_rd0[i] = 0; e_rd1[i] = 0; e_dn0[i] = 0; e_dn1[i] = 0;
            e_addr[i] = '0; e_daddr[i] = '0;
        end
    endtask

    task automatic check_regs();
        chk("bram_en", 64'(bram_en), 64'(e_en[cyc]));
        if (e_en[cyc]) chk("bram_addr", 64'(bram_addr), 64'(e_addr[cyc]));
        chk("rd0_valid", 64'(rd0_valid), 64'(e_rd0[cyc]));
        chk("rd1_valid", 64'(rd1_valid), 64'(e_rd1[cyc]));
        if (e_rd0[cyc] || e_rd1[cyc]) chk("rd_data", rd_data, mem(e_daddr[cyc]));
        chk("done0", 64'(done0), 64'(e_dn0[cyc]));
        chk("done1", 64'(done1), 64'(e_dn1[cyc]));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bram_en"},   64'(bram_en),    64'(0));
        chk({tag, "_bram_addr"}, 64'(bram_addr),  64'(0));
        chk({tag, "_rd0"},       64'(rd0_valid),  64'(0));
        chk({tag, "_rd1"},       64'(rd1_valid),  64'(0));
        chk({tag, "_done0"},     64'(done0),      64'(0));
        chk({tag, "_done1"},     64'(done1),      64'(0));
        chk({tag, "_ready0"},    64'(req0_ready), 64'(0));
        chk({tag, "_ready1"},    64'(req1_ready), 64'(0));
    endtask

    // One cycle: inputs for cycle cyc are already driven; check grants, update
    // the model, advance a clock and check the registered outputs of the next cycle.
    task automatic tick();
        bit idle, r0, r1, o;
        logic [ADDR_W-1:0] a;
        int l;
        #1;
        idle = (cyc >= free_at) && !ap_done;
        r0 = idle && req0_valid && (!req1_valid || lg);
        r1 = idle && req1_valid && (!req0_valid || !lg);
        chk("req0_ready", 64'(req0_ready), 64'(r0));
        chk("req1_ready", 64'(req1_ready), 64'(r1));
        if (req0_ready && req0_valid) obs_grants.push_back(0);
        if (req1_ready && req1_valid) obs_grants.push_back(1);
        if (ap_done) begin
            clear_from(cyc + 1);
            free_at = cyc + 1;
            lg = 1'b1;
        end else if (r0 || r1) begin
            o  = r1;
            a  = r1 ? req1_addr : req0_addr;
            l  = r1 ? int'(req1_len) : int'(req0_len);
            lg = o;
            if (l == 0) begin
                if (o) e_dn1[cyc+1] = 1; else e_dn0[cyc+1] = 1;
                free_at = cyc + 2;
            end else begin
                for (int k = 0; k < l; k++) begin
                    e_en[cyc+1+k]   = 1;
                    e_addr[cyc+1+k] = ADDR_W'(int'(a) + k);
                    if (o) e_rd1[cyc+1+RD_LAT+k] = 1; else e_rd0[cyc+1+RD_LAT+k] = 1;
                    e_daddr[cyc+1+RD_LAT+k] = ADDR_W'(int'(a) + k);
                end
                if (o) e_dn1[cyc+l+RD_LAT] = 1; else e_dn0[cyc+l+RD_LAT] = 1;
                free_at = cyc + l + RD_LAT + 1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        check_regs();
    endtask

    // Reset release resynchronises the model: empty timeline, round-robin pointer at 1
    task automatic release_reset();
        req0_valid = 0; req1_valid = 0; ap_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        clear_from(0);
        free_at = cyc;
        lg = 1'b1;
        check_regs();
    endtask

    initial begin
        // Reset state, with requests pending so ready gating is exercised
        req0_valid = 1; req1_valid = 1; req0_len = 5'd3; req1_len = 5'd3;
        #3;
        check_all_zero("rst");
        release_reset();

        // Both requesters valid continuously: grants alternate starting with 0
        obs_grants.delete();
        req0_valid = 1; req0_addr = 12'h100; req0_len = 5'd2;
        req1_valid = 1; req1_addr = 12'h200; req1_len = 5'd2;
        repeat (16) tick();
        req0_valid = 0; req1_valid = 0;
        repeat (6) tick();
        chk("grant_count", 64'(obs_grants.size()), 64'(4));
        for (int i = 0; i < 4 && i < obs_grants.size(); i++)
            chk("grant_order", 64'(obs_grants[i]), 64'(exp_g[i]));

        // Requester 0 alone, addr 0x010 len 4; a follow-up request waits for T+7
        req0_valid = 1; req0_addr = 12'h010; req0_len = 5'd4;
        tick();
        req0_addr = 12'h020; req0_len = 5'd1;
        repeat (7) tick();
        req0_valid = 0;
        repeat (5) tick();

        // Address wrap on requester 1
        req1_valid = 1; req1_addr = 12'hFFE; req1_len = 5'd4;
        tick();
        req1_valid = 0;
        repeat (8) tick();

        // Zero-length bursts back to back
        req0_valid = 1; req0_addr = 12'h055; req0_len = 5'd0;
        repeat (3) tick();
        req0_valid = 0;
        repeat (4) tick();

        // Layer-end clear after two of eight issues
        req0_valid = 1; req0_addr = 12'h300; req0_len = 5'd8;
        tick();
        req0_valid = 0;
        tick();
        ap_done = 1;
        tick();
        ap_done = 0;
        repeat (6) tick();
        req1_valid = 1; req1_addr = 12'h400; req1_len = 5'd2;
        tick();
        req1_valid = 0;
        repeat (6) tick();

        // Asynchronous reset in the middle of DRAIN, off the clock edge
        req0_valid = 1; req0_addr = 12'h500; req0_len = 5'd3;
        tick();
        req0_valid = 0;
        repeat (3) tick();
        chk("pre_arst_rd0", 64'(rd0_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        req1_valid = 1;
        #1;
        chk("arst_ready1", 64'(req1_ready), 64'(0));
        repeat (2) @(posedge clk);
        release_reset();

        // Randomised traffic, including occasional layer-end clears
        for (int n = 0; n < 500; n++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_addr  = ADDR_W'($urandom);
            req0_len   = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 4));
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_addr  = ADDR_W'($urandom);
            req1_len   = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 4));
            ap_done    = ($urandom_range(0, 79) == 0);
            tick();
        end
        req0_valid = 0; req1_valid = 0; ap_done = 0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, observed cycle=%0d required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
